// File: rtl/ula_pkg.sv
// Shared ULA definitions: operand transform encodings and the width of the
// low field that the extend/shift transforms operate on.
package ula_pkg;

  localparam int ULA_LOW_BITS = 16;

  typedef enum logic [1:0] {
    PASS       = 2'b00,
    SEXT16     = 2'b01,
    SEXT16_SL2 = 2'b10,
    ZEXT16     = 2'b11
  } ula_mode_e;

endpackage

// File: rtl/ula_src_b_xform.sv
// Combinational source-B operand path: picks a data channel or the constant,
// then applies the immediate-style extend/shift transform.
module ula_src_b_xform
  import ula_pkg::*;
#(
  parameter int          WIDTH     = 32,
  parameter int          NCH       = 3,
  parameter int unsigned CONST_VAL = 4,
  localparam int         SELW      = $clog2(NCH + 1)
) (
  input  logic [SELW-1:0]      selector,
  input  logic [1:0]           mode,
  input  logic [NCH*WIDTH-1:0] data_in,
  output logic [WIDTH-1:0]     xf_data,
  output logic                 xf_err
);

  logic [WIDTH-1:0] sel_val_s;
  logic [WIDTH-1:0] sext_s;

  // Channel select; codes above the constant slot yield zero and flag an error.
  always_comb begin
    sel_val_s = '0;
    xf_err    = 1'b0;
    if (int'(selector) < NCH) begin
      sel_val_s = WIDTH'(data_in >> (int'(selector) * WIDTH));
    end else if (int'(selector) == NCH) begin
      sel_val_s = WIDTH'(CONST_VAL);
    end else begin
      xf_err = 1'b1;
    end
  end

  assign sext_s = WIDTH'($signed(sel_val_s[ULA_LOW_BITS-1:0]));

  // Post-select transform; the shifted form drops bits carried past WIDTH.
  always_comb begin
    xf_data = sel_val_s;
    case (ula_mode_e'(mode))
      PASS:       xf_data = sel_val_s;
      SEXT16:     xf_data = sext_s;
      SEXT16_SL2: xf_data = {sext_s[WIDTH-3:0], 2'b00};
      ZEXT16:     xf_data = WIDTH'(sel_val_s[ULA_LOW_BITS-1:0]);
      default:    xf_data = sel_val_s;
    endcase
  end

endmodule

// File: rtl/ula_src_b_pipe.sv
// Source-B operand stage: select+transform followed by a two-entry skid
// buffer so in_ready is a pure register output.
module ula_src_b_pipe
  import ula_pkg::*;
#(
  parameter int          WIDTH     = 32,
  parameter int          NCH       = 3,
  parameter int unsigned CONST_VAL = 4,
  localparam int         SELW      = $clog2(NCH + 1)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [SELW-1:0]      selector,
  input  logic [1:0]           mode,
  input  logic [NCH*WIDTH-1:0] data_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     data_out,
  output logic                 out_err,
  output logic [15:0]          beat_count
);

  logic [WIDTH-1:0] xf_data_s;
  logic             xf_err_s;
  logic             accept_s;
  logic             deliver_s;
  logic             skid_valid_nxt_s;

  logic [WIDTH-1:0] main_data_r;
  logic             main_err_r;
  logic             main_valid_r;
  logic [WIDTH-1:0] skid_data_r;
  logic             skid_err_r;
  logic             skid_valid_r;
  logic             in_ready_r;
  logic [15:0]      beat_count_r;

  ula_src_b_xform #(
    .WIDTH     (WIDTH),
    .NCH       (NCH),
    .CONST_VAL (CONST_VAL)
  ) u_xform (
    .selector (selector),
    .mode     (mode),
    .data_in  (data_in),
    .xf_data  (xf_data_s),
    .xf_err   (xf_err_s)
  );

  assign accept_s  = in_valid & in_ready_r;
  assign deliver_s = main_valid_r & out_ready;

  // Skid occupancy for the next cycle; in_ready is registered from it.
  always_comb begin
    skid_valid_nxt_s = skid_valid_r;
    if (skid_valid_r && deliver_s) begin
      skid_valid_nxt_s = 1'b0;
    end else if (main_valid_r && !deliver_s && accept_s) begin
      skid_valid_nxt_s = 1'b1;
    end else begin
      skid_valid_nxt_s = skid_valid_r;
    end
  end

  // Main/skid registers, ready flag and delivered-beat counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      main_data_r  <= '0;
      main_err_r   <= 1'b0;
      main_valid_r <= 1'b0;
      skid_data_r  <= '0;
      skid_err_r   <= 1'b0;
      skid_valid_r <= 1'b0;
      in_ready_r   <= 1'b0;
      beat_count_r <= 16'd0;
    end else begin
      if (skid_valid_r && deliver_s) begin
        main_data_r <= skid_data_r;
        main_err_r  <= skid_err_r;
      end else if (!main_valid_r || deliver_s) begin
        main_valid_r <= accept_s;
        if (accept_s) begin
          main_data_r <= xf_data_s;
          main_err_r  <= xf_err_s;
        end
      end else if (accept_s) begin
        // Main is stalled: park the incoming beat behind it.
        skid_data_r <= xf_data_s;
        skid_err_r  <= xf_err_s;
      end
      skid_valid_r <= skid_valid_nxt_s;
      in_ready_r   <= ~skid_valid_nxt_s;
      if (deliver_s) begin
        beat_count_r <= beat_count_r + 16'd1;
      end
    end
  end

  assign in_ready   = in_ready_r;
  assign out_valid  = main_valid_r;
  assign data_out   = main_data_r;
  assign out_err    = main_err_r;
  assign beat_count = beat_count_r;

endmodule

// File: tb/tb_ula_src_b_pipe.sv
// Scoreboard bench for ula_src_b_pipe; NCH=4 so the 3-bit selector can carry
// out-of-range codes (5..7).
module tb_ula_src_b_pipe;

  localparam int W  = 32;
  localparam int N  = 4;
  localparam int SW = 3;

  logic           clk = 1'b0;
  logic           reset_n;
  logic           in_valid;
  logic           in_ready;
  logic [SW-1:0]  selector;
  logic [1:0]     mode;
  logic [N*W-1:0] data_in;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   data_out;
  logic           out_err;
  logic [15:0]    beat_count;

  int          checks = 0;
  int          errors = 0;
  logic [32:0] sb_q[$];
  logic [15:0] exp_count = 16'd0;
  bit          rand_done;

  ula_src_b_pipe #(.WIDTH(W), .NCH(N), .CONST_VAL(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .selector   (selector),
    .mode       (mode),
    .data_in    (data_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .data_out   (data_out),
    .out_err    (out_err),
    .beat_count (beat_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: {err, data}
  function automatic logic [32:0] model(input logic [2:0] s, input logic [1:0] m,
                                         input logic [N*W-1:0] d);
    logic [31:0] v;
    if (int'(s) < N) v = d[int'(s)*32 +: 32];
    else if (int'(s) == N) v = 32'd4;
    else return {1'b1, 32'h0};
    case (m)
      2'b00:   return {1'b0, v};
      2'b01:   return {1'b0, {16{v[15]}}, v[15:0]};
      2'b10:   return {1'b0, {14{v[15]}}, v[15:0], 2'b00};
      default: return {1'b0, 16'h0000, v[15:0]};
    endcase
  endfunction

  // Scoreboard: predicts edge events from register outputs at the falling edge.
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check_eq("extra_beat", {63'd0, out_valid}, 64'd0);
        end else begin
          logic [32:0] e;
          e = sb_q.pop_front();
          check_eq("data", {32'd0, data_out}, {32'd0, e[31:0]});
          check_eq("err", {63'd0, out_err}, {63'd0, e[32]});
          check_eq("count", {48'd0, beat_count}, {48'd0, exp_count});
          exp_count = exp_count + 16'd1;
        end
      end
      if (in_valid && in_ready) sb_q.push_back(model(selector, mode, data_in));
    end
  end

  // Present one beat; returns #1 after the accepting edge.
  task automatic send(input logic [2:0] s, input logic [1:0] m, input logic [N*W-1:0] d);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1; selector = s; mode = m; data_in = d;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) check_eq("accept_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_expect(input string tag, input logic [2:0] s, input logic [1:0] m,
                             input logic [N*W-1:0] d, input logic [31:0] ed, input logic ee);
    send(s, m, d);
    check_eq({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
    check_eq({tag, "_data"}, {32'd0, data_out}, {32'd0, ed});
    check_eq({tag, "_err"}, {63'd0, out_err}, {63'd0, ee});
  endtask

  task automatic wait_drain();
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 500; t++) begin
      @(negedge clk);
      if (sb_q.size() == 0 && !out_valid) begin ok = 1'b1; break; end
    end
    if (!ok) check_eq("drain_timeout", 64'(sb_q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [N*W-1:0] d;
    reset_n = 1'b0; in_valid = 1'b0; selector = '0; mode = 2'b00;
    data_in = '0; out_ready = 1'b0;

    #12;
    check_eq("rst_in_ready", {63'd0, in_ready}, 64'd0);
    check_eq("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check_eq("rst_data", {32'd0, data_out}, 64'd0);
    check_eq("rst_err", {63'd0, out_err}, 64'd0);
    check_eq("rst_count", {48'd0, beat_count}, 64'd0);
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    check_eq("ready_after_rst", {63'd0, in_ready}, 64'd1);
    out_ready = 1'b1;

    // Constant channel, then count after delivery
    send_expect("const", 3'd4, 2'b00, '0, 32'h0000_0004, 1'b0);
    @(posedge clk); #1;
    check_eq("count_one", {48'd0, beat_count}, 64'd1);
    send_expect("const_sl2", 3'd4, 2'b10, '0, 32'h0000_0010, 1'b0);

    // Transforms on channel 1
    d = '0; d[63:32] = 32'h0000_FFFC; d[31:0] = 32'h1234_5678;
    send_expect("m10", 3'd1, 2'b10, d, 32'hFFFF_FFF0, 1'b0);
    send_expect("m01", 3'd1, 2'b01, d, 32'hFFFF_FFFC, 1'b0);
    send_expect("m11", 3'd1, 2'b11, d, 32'h0000_FFFC, 1'b0);
    send_expect("m00", 3'd1, 2'b00, d, 32'h0000_FFFC, 1'b0);

    // Out-of-range selector flags only its own beat
    send_expect("bad_sel", 3'd5, 2'b00, d, 32'h0000_0000, 1'b1);
    send_expect("after_bad", 3'd0, 2'b00, d, 32'h1234_5678, 1'b0);
    wait_drain();

    // 8-beat stream with out_ready low for cycles 3-5
    fork
      begin
        for (int k = 1; k <= 8; k++) send(3'd0, 2'b00, (N*W)'(k));
      end
      begin
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_eq("stall_ready_c2", {63'd0, in_ready}, 64'd1);
        out_ready = 1'b0;
        for (int c = 3; c <= 5; c++) begin
          @(posedge clk); #1;
          check_eq("stall_ready", {63'd0, in_ready}, 64'd0);
          check_eq("stall_valid", {63'd0, out_valid}, 64'd1);
          check_eq("stall_data", {32'd0, data_out}, 64'd2);
        end
        out_ready = 1'b1;
      end
    join
    wait_drain();

    // Random traffic with random backpressure
    rand_done = 1'b0;
    fork
      begin
        for (int k = 0; k < 60; k++)
          send(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
               {$urandom, $urandom, $urandom, $urandom});
        rand_done = 1'b1;
      end
      begin
        for (int c = 0; c < 2000 && !rand_done; c++) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 2) != 0);
        end
        out_ready = 1'b1;
      end
    join
    out_ready = 1'b1;
    wait_drain();

    // Reset with skid full discards both buffered beats
    out_ready = 1'b0;
    send(3'd0, 2'b00, (N*W)'(32'hAAAA_0001));
    send(3'd0, 2'b00, (N*W)'(32'hAAAA_0002));
    check_eq("skid_full_ready", {63'd0, in_ready}, 64'd0);
    #2 reset_n = 1'b0;
    #1;
    check_eq("mid_rst_valid", {63'd0, out_valid}, 64'd0);
    check_eq("mid_rst_ready", {63'd0, in_ready}, 64'd0);
    check_eq("mid_rst_count", {48'd0, beat_count}, 64'd0);
    sb_q.delete();
    exp_count = 16'd0;
    @(posedge clk); #3;
    reset_n = 1'b1; out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check_eq("no_stale_valid", {63'd0, out_valid}, 64'd0);
    check_eq("post_rst_ready", {63'd0, in_ready}, 64'd1);

    // Counter wrap
    for (int k = 0; k < 65535; k++) send(3'd4, 2'b00, '0);
    wait_drain();
    check_eq("count_ffff", {48'd0, beat_count}, 64'h0000_FFFF);
    send(3'd4, 2'b00, '0);
    @(posedge clk); #1;
    check_eq("count_wrap", {48'd0, beat_count}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
